// File: rtl/adder_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin adder arbiter.
// Holds the default sizes, the requester-ID width rule and the response-register state encoding.
package adder_rr_arbiter_pkg;

    localparam int DEFAULT_N    = 4;
    localparam int DEFAULT_REQS = 4;

    function automatic int id_width(input int reqs);
        return (reqs <= 1) ? 1 : $clog2(reqs);
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/adder.sv
// Existing combinational adder: full-width sum with the carry-out in the MSB.
module Adder #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n:0]   s
);

    assign s = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_rr_arbiter_rr_grant_picker.sv
// Round-robin picker: first valid requester at or above the pointer, wrapping modulo REQS.
// Produces a one-hot grant (only when enabled) and the binary index of the winner.
module rr_grant_picker #(
    parameter int REQS = 4,
    parameter int IDW  = 2
) (
    input  logic [REQS-1:0] req_valid,
    input  logic [IDW-1:0]  pointer,
    input  logic            enable,
    output logic [REQS-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [REQS-1:0] rotated;
    logic [IDW-1:0]  offset;
    logic            found;

    // Rotate so that bit 0 is the pointer position; REQS is a power of two, so the index wraps naturally.
    generate
        for (genvar gi = 0; gi < REQS; gi++) begin : g_rot
            logic [IDW-1:0] src_idx;
            assign src_idx     = pointer + IDW'(gi);
            assign rotated[gi] = req_valid[src_idx];
        end
    endgenerate

    always_comb begin
        offset = '0;
        found  = 1'b0;
        for (int k = REQS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = IDW'(k);
            end
        end
    end

    assign grant_idx = pointer + offset;

    always_comb begin
        grant = '0;
        if (enable && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one adder between REQS requesters with round-robin arbitration and a
// single registered, ID-tagged response slot that supports one addition per cycle.
module adder_rr_arbiter
    import adder_rr_arbiter_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int REQS = DEFAULT_REQS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REQS-1:0]           req_valid,
    input  logic [REQS*N-1:0]         req_augend,
    input  logic [REQS*N-1:0]         req_addend,
    output logic [REQS-1:0]           req_ready,
    output logic                      rsp_valid,
    output logic [N:0]                rsp_sum,
    output logic [id_width(REQS)-1:0] rsp_id,
    input  logic                      rsp_ready,
    output logic [15:0]               txn_count
);

    localparam int IDW = id_width(REQS);

    state_t         state_reg;
    state_t         state_next;
    logic [IDW-1:0] pointer_reg;
    logic [N:0]     rsp_sum_reg;
    logic [IDW-1:0] rsp_id_reg;
    logic [15:0]    txn_count_reg;

    logic           can_accept;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic [N-1:0]   sel_augend;
    logic [N-1:0]   sel_addend;
    logic [N:0]     sum;

    // The slot can take a new result when empty or when its current result drains this cycle.
    assign can_accept = (state_reg == ST_EMPTY) || rsp_ready;

    rr_grant_picker #(
        .REQS (REQS),
        .IDW  (IDW)
    ) u_picker (
        .req_valid (req_valid),
        .pointer   (pointer_reg),
        .enable    (can_accept && !rst),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    assign grant_any  = |req_ready;
    assign sel_augend = req_augend[grant_idx*N +: N];
    assign sel_addend = req_addend[grant_idx*N +: N];

    Adder #(
        .n (N)
    ) u_adder (
        .a (sel_augend),
        .b (sel_addend),
        .s (sum)
    );

    always_comb begin
        state_next = state_reg;
        if (grant_any) begin
            state_next = ST_HOLD;
        end else if (state_reg == ST_HOLD && rsp_ready) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_EMPTY;
            pointer_reg   <= '0;
            rsp_sum_reg   <= '0;
            rsp_id_reg    <= '0;
            txn_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_any) begin
                rsp_sum_reg   <= sum;
                rsp_id_reg    <= grant_idx;
                pointer_reg   <= grant_idx + IDW'(1);
                txn_count_reg <= txn_count_reg + 16'd1;
            end
        end
    end

    assign rsp_valid = (state_reg == ST_HOLD);
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_id    = rsp_id_reg;
    assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Randomized and directed bench for adder_rr_arbiter against a behavioural
// model of the arbitration rules, response slot and transaction counter.
module tb_adder_rr_arbiter;

    localparam int N    = 4;
    localparam int REQS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [REQS-1:0]   req_valid;
    logic [REQS*N-1:0] req_augend;
    logic [REQS*N-1:0] req_addend;
    logic [REQS-1:0]   req_ready;
    logic              rsp_valid;
    logic [N:0]        rsp_sum;
    logic [1:0]        rsp_id;
    logic              rsp_ready;
    logic [15:0]       txn_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_valid = 0;
    int m_sum   = 0;
    int m_id    = 0;
    int m_ptr   = 0;
    int m_count = 0;

    always #5 clk = ~clk;

    adder_rr_arbiter #(
        .N    (N),
        .REQS (REQS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_augend (req_augend),
        .req_addend (req_addend),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_sum    (rsp_sum),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .txn_count  (txn_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Winner under the round-robin rule, or -1 when nothing may be granted.
    function automatic int model_pick();
        if (rst) return -1;
        if (m_valid && !rsp_ready) return -1;
        for (int k = 0; k < REQS; k++) begin
            int idx;
            idx = (m_ptr + k) % REQS;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int aug_of(input int i);
        return int'((req_augend >> (i * N)) & 4'hF);
    endfunction

    function automatic int add_of(input int i);
        return int'((req_addend >> (i * N)) & 4'hF);
    endfunction

    // One clock: inputs must already be driven (after a negedge).
    task automatic step();
        int g;
        logic [REQS-1:0] exp_ready;
        #1;
        g = model_pick();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_sum = 0; m_id = 0; m_ptr = 0; m_count = 0;
        end else if (g >= 0) begin
            m_sum   = aug_of(g) + add_of(g);
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % REQS;
            m_count = (m_count + 1) % 65536;
            $display("txn %0d: id=%0d a=%0d b=%0d sum=%0d", m_count, g, aug_of(g), add_of(g), m_sum);
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check("rsp_sum",   32'(rsp_sum),   32'(m_sum));
        check("rsp_id",    32'(rsp_id),    32'(m_id));
        check("txn_count", 32'(txn_count), 32'(m_count));
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_augend[i*N +: N] = N'(a);
        req_addend[i*N +: N] = N'(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [REQS-1:0] pending;

    initial begin
        rst = 1'b1; req_valid = '1; req_augend = '0; req_addend = '0; rsp_ready = 1'b1;
        @(negedge clk);

        // Reset held two cycles with all requesters asking
        step();
        step();
        rst = 1'b0; req_valid = '0;
        step();
        check("post_reset_count", 32'(txn_count), 32'd0);

        // Single request from requester 2 with carry-out
        req_valid = 4'b0100; set_req(2, 15, 1);
        step();
        check("single_sum", 32'(rsp_sum), 32'h10);
        check("single_id", 32'(rsp_id), 32'd2);

        // Round robin from a fresh pointer
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < REQS; i++) set_req(i, i + 1, i + 2);
        for (int i = 0; i < 5; i++) step();
        check("rr_count", 32'(txn_count), 32'd5);

        // Backpressure: hold 3+4, requester 1 waits until rsp_ready rises
        do_reset();
        req_valid = 4'b0010; set_req(1, 3, 4);
        step();
        check("bp_first", 32'(rsp_sum), 32'd7);
        set_req(1, 5, 6); rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("bp_held", 32'(rsp_sum), 32'd7);
        rsp_ready = 1'b1;
        step();
        check("bp_new", 32'(rsp_sum), 32'd11);
        req_valid = '0;
        step();

        // Exhaustive sweep on requester 3
        req_valid = 4'b1000;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                set_req(3, a, b);
                step();
            end
        end

        // Reset while holding a backpressured result
        rsp_ready = 1'b0; req_valid = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; req_valid = 4'b1010; rsp_ready = 1'b1;
        step();
        check("after_rst_id", 32'(rsp_id), 32'd1);

        // Random traffic; requesters hold valid and data until accepted
        pending = '0; req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < REQS; i++) begin
                if (!pending[i] && ($urandom_range(0, 2) != 0)) begin
                    pending[i] = 1'b1;
                    set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                end
            end
            req_valid = pending;
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            pending = pending & ~req_ready;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one combinational N-bit Adder instance between REQS independent requesters.
- Uses round-robin arbitration, a valid/ready handshake on each requester port, and a single registered response channel tagged with the requester ID.
- Sits between ALU-level clients and the shared adder datapath. Sustains one addition per cycle when the response side is not backpressured.

Parameters:
- N, 4, operand width in bits; sum width is N+1.
- REQS, 4, number of requesters; power of two, at least 2.
- IDW, $clog2(REQS), width of requester ID (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  REQS  per-requester request valid.
- req_augend  input  REQS*N  packed augends; requester i occupies bits [i*N +: N].
- req_addend  input  REQS*N  packed addends, same packing.
- req_ready  output  REQS  one-hot (or zero) grant/accept strobe.
- rsp_valid  output  1  registered result valid.
- rsp_sum  output  N+1  registered sum; MSB is carry-out.
- rsp_id  output  IDW  index of the requester that produced rsp_sum.
- rsp_ready  input  1  consumer accepts the response.
- txn_count  output  16  count of accepted transactions; wraps.

Behaviour:
- Reset: all of the following are cleared on the next rising edge while rst is high:
  - rsp_valid=0, rsp_sum=0, rsp_id=0, txn_count=0.
  - Priority pointer = 0, so requester 0 has highest priority after reset.
  - req_ready=0 for every cycle rst is high.
- FSM, two states:
  - EMPTY: output register holds no valid result.
  - HOLD: rsp_valid=1.
- Accept condition: can_accept = (state==EMPTY) || rsp_ready.
- Grant (combinational): when can_accept, choose the first i with req_valid[i]=1, scanning from the pointer upward modulo REQS.
  - req_ready = onehot(i) in that case; otherwise req_ready=0.
  - req_ready never asserts for a requester with req_valid=0.
- Datapath:
  - The granted requester's augend/addend are muxed into Adder.
  - On the handshake edge: rsp_sum <= augend+addend (full N+1 bits, no truncation), rsp_id <= i, state <= HOLD.
- Latency: 1 cycle. A transaction accepted at edge k has its result visible from just after edge k.
- Drain: rsp_valid && rsp_ready with no new grant -> state <= EMPTY. rsp_sum and rsp_id retain their last values.
- Simultaneous drain and accept: new result loaded, state stays HOLD. Throughput is 1 per cycle.
- Backpressure: while in HOLD with rsp_ready=0:
  - req_ready=0.
  - rsp_sum and rsp_id are held stable.
  - Requesters keep valid and data stable until accepted; the arbiter relies on this.
- Pointer update: on a grant to i, pointer <= (i+1) mod REQS. With no grant, the pointer is unchanged.
  - A continuously requesting requester waits at most REQS-1 grants.
- txn_count increments by 1 on every accepted request, wrapping 16'hFFFF -> 0.
- rsp_ready is ignored when rsp_valid=0.
- Reset mid-HOLD discards the held result and does not increment txn_count.
- The arbiter has no combinational path from rsp_ready to rsp_* outputs. The paths rsp_ready -> req_ready and req_valid -> req_ready are combinational, by design.

Decomposition:
- Shared package constants: default N, REQS, IDW computation, state encodings EMPTY=1'b0 and HOLD=1'b1.
- Sub-module rr_grant_picker: inputs req_valid, pointer, enable; outputs one-hot grant and binary index.
- The existing Adder module is instantiated once, unmodified, with n=N.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0 throughout; after release rsp_valid=0, txn_count=0.
- Single request: req_valid=4'b0100, augend[2]=4'hF, addend[2]=4'h1, rsp_ready=1 -> req_ready=4'b0100 that cycle; next cycle rsp_valid=1, rsp_sum=5'b10000, rsp_id=2, txn_count=1.
- Round-robin: req_valid=4'b1111 held with rsp_ready=1 for 5 cycles -> grants 0,1,2,3,0 on consecutive cycles, rsp_id follows one cycle later, txn_count=5.
- Backpressure: result 5'b00111 held, rsp_ready=0 for 3 cycles with req_valid=4'b0010 -> req_ready=0 and rsp_sum stable. Raising rsp_ready -> req_ready[1]=1 the same cycle, and the new sum appears the next cycle.
- Exhaustive arithmetic: requester 3 sweeps all 256 (augend, addend) pairs back-to-back -> every rsp_sum equals augend+addend in 5 bits, with rsp_id=3.
- Reset mid-operation: assert rst while in HOLD with rsp_ready=0 -> next cycle rsp_valid=0 and txn_count=0. Then req_valid=4'b1010 -> requester 1 granted first (pointer back at 0).
